// File: rtl/o_buffer_pkg.sv
// o_buffer_pkg: state encodings and shared constants for the systolic output buffer.
package o_buffer_pkg;
    typedef enum logic [1:0] {C_IDLE, C_CAPT, C_FLUSH} cap_state_t;
    typedef enum logic {D_IDLE, D_RUN} drn_state_t;
    localparam logic MODE_OVERWRITE = 1'b0;
    localparam logic MODE_ACC = 1'b1;
    localparam int ACC_LAT = 2;
    localparam int SKID_DEPTH = 2;
endpackage

// File: rtl/obuf_bank.sv
// obuf_bank: one column bank with overwrite or read-modify-write accumulate pipeline.
// O_BUF_SAT_EN selects signed-saturating accumulation instead of wrapping.
module obuf_bank import o_buffer_pkg::*; #(
    parameter int OUT_WIDTH = 32,
    parameter int RAM_DEPTH = 256,
    parameter int ADDR_WIDTH = $clog2(RAM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  acc_mode,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [OUT_WIDTH-1:0]  wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [OUT_WIDTH-1:0]  rd_data
);
    logic [OUT_WIDTH-1:0] mem [RAM_DEPTH];
    logic v1, m1, v2, we;
    logic [ADDR_WIDTH-1:0] a1, a2, wa;
    logic [OUT_WIDTH-1:0] d1, s2, sum, wsum, wd;
    assign wsum = rd_data + d1;
`ifdef O_BUF_SAT_EN
    logic ovf;
    assign ovf = (rd_data[OUT_WIDTH-1] == d1[OUT_WIDTH-1]) && (wsum[OUT_WIDTH-1] != d1[OUT_WIDTH-1]);
    assign sum = ovf ? {d1[OUT_WIDTH-1], {(OUT_WIDTH-1){~d1[OUT_WIDTH-1]}}} : wsum;
`else
    assign sum = wsum;
`endif
    // overwrite commits one cycle after the beat, accumulate two cycles after
    assign we = v2 || (v1 && m1 == MODE_OVERWRITE);
    assign wa = v2 ? a2 : a1;
    assign wd = v2 ? s2 : d1;
    always_ff @(posedge clk) begin
        rd_data <= mem[wr_en ? wr_addr : rd_addr];
        if (we) mem[wa] <= wd;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1 <= 1'b0;
            m1 <= MODE_OVERWRITE;
            v2 <= 1'b0;
            a1 <= '0;
            a2 <= '0;
            d1 <= '0;
            s2 <= '0;
        end else begin
            v1 <= wr_en;
            m1 <= acc_mode;
            a1 <= wr_addr;
            d1 <= wr_data;
            v2 <= v1 && m1 == MODE_ACC;
            a2 <= a1;
            s2 <= sum;
        end
    end
endmodule

// File: rtl/o_buffer_acc.sv
// o_buffer_acc: de-skewing per-column output buffer with overwrite/accumulate capture and row-major drain.
// O_BUF_SAT_EN (see obuf_bank) enables saturating accumulation.
module o_buffer_acc import o_buffer_pkg::*; #(
    parameter int ARRAY_M = 8,
    parameter int OUT_WIDTH = 32,
    parameter int RAM_DEPTH = 256,
    parameter int ADDR_WIDTH = $clog2(RAM_DEPTH),
    parameter int CNT_WIDTH = ADDR_WIDTH + 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [$clog2(ARRAY_M):0]     cfg_num_cols,
    input  logic [CNT_WIDTH-1:0]         cfg_num_rows,
    input  logic [ADDR_WIDTH-1:0]        cfg_base_addr,
    input  logic                         cfg_acc_mode,
    input  logic                         start,
    input  logic                         in_valid,
    input  logic [ARRAY_M*OUT_WIDTH-1:0] in_data,
    output logic                         busy,
    output logic                         done,
    input  logic                         drain_start,
    input  logic [ADDR_WIDTH-1:0]        drain_base,
    input  logic [CNT_WIDTH-1:0]         drain_len,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [OUT_WIDTH-1:0]         out_data,
    output logic                         out_last,
    output logic                         cfg_err
);
    localparam int CW = $clog2(ARRAY_M) + 1;
    localparam int IW = $clog2(ARRAY_M);
    localparam int BW = CNT_WIDTH + 1;
    cap_state_t cap_state, cap_next;
    drn_state_t drn_state, drn_next;
    logic [CW-1:0] ncols, cols_in, c;
    logic [CNT_WIDTH-1:0] nrows, dlen, r;
    logic [ADDR_WIDTH-1:0] base, dbase;
    logic acc, start_ok, drn_ok;
    logic [BW-1:0] beat, last_beat;
    logic [1:0] fcnt, cnt, lvl;
    logic [2:0] lvl_n;
    logic issued_all, issue, last_issue, pend, pend_last, pop, l0, l1;
    logic [IW-1:0] pend_col;
    logic [OUT_WIDTH-1:0] e0, e1;
    logic [OUT_WIDTH-1:0] rd_bus [ARRAY_M];
    assign cols_in = (cfg_num_cols > CW'(ARRAY_M)) ? CW'(ARRAY_M) : cfg_num_cols;
    assign start_ok = start && cap_state == C_IDLE && drn_state == D_IDLE;
    assign drn_ok = drain_start && cap_state == C_IDLE && drn_state == D_IDLE && !start;
    assign last_beat = BW'(nrows) + BW'(ncols) - BW'(2);
    assign busy = cap_state != C_IDLE;
    assign done = cap_state == C_FLUSH && fcnt == 2'(ACC_LAT - 1);
    always_comb begin
        cap_next = cap_state;
        if (cap_state == C_IDLE && start_ok)
            cap_next = (cols_in == '0 || cfg_num_rows == '0) ? C_FLUSH : C_CAPT;
        else if (cap_state == C_CAPT && in_valid && beat == last_beat)
            cap_next = C_FLUSH;
        else if (done)
            cap_next = C_IDLE;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap_state <= C_IDLE;
            ncols <= '0;
            nrows <= '0;
            base <= '0;
            acc <= MODE_OVERWRITE;
            beat <= '0;
            fcnt <= '0;
        end else begin
            cap_state <= cap_next;
            if (start_ok) begin
                ncols <= cols_in;
                nrows <= cfg_num_rows;
                base <= cfg_base_addr;
                acc <= cfg_acc_mode;
                beat <= '0;
            end else if (cap_state == C_CAPT && in_valid) begin
                beat <= beat + 1'b1;
            end
            fcnt <= (cap_state == C_FLUSH) ? fcnt + 1'b1 : '0;
        end
    end
    // bank m sees beat b as row b-m, which undoes the array's diagonal skew
    for (genvar g = 0; g < ARRAY_M; g++) begin : g_bank
        logic [BW-1:0] off;
        logic wen;
        assign off = beat - BW'(g);
        assign wen = cap_state == C_CAPT && in_valid && BW'(g) < BW'(ncols) && beat >= BW'(g) && off < BW'(nrows);
        obuf_bank #(.OUT_WIDTH(OUT_WIDTH), .RAM_DEPTH(RAM_DEPTH), .ADDR_WIDTH(ADDR_WIDTH)) u_bank (
            .clk(clk),
            .reset(reset),
            .acc_mode(acc),
            .wr_en(wen),
            .wr_addr(base + off[ADDR_WIDTH-1:0]),
            .wr_data(in_data[OUT_WIDTH*g +: OUT_WIDTH]),
            .rd_addr(dbase + r[ADDR_WIDTH-1:0]),
            .rd_data(rd_bus[g])
        );
    end
    assign pop = out_valid && out_ready;
    assign lvl = cnt - {1'b0, pop};
    assign lvl_n = {1'b0, cnt} + {2'b0, pend} - {2'b0, pop};
    // only issue a read when the skid buffer is guaranteed room for its data
    assign issue = drn_state == D_RUN && !issued_all && lvl_n < 3'(SKID_DEPTH);
    assign last_issue = r == dlen - 1'b1 && c == ncols - 1'b1;
    assign out_valid = cnt != '0;
    assign out_data = e0;
    assign out_last = out_valid && l0;
    always_comb begin
        drn_next = drn_state;
        if (drn_state == D_IDLE)
            drn_next = (drn_ok && drain_len != '0 && ncols != '0) ? D_RUN : D_IDLE;
        else if (pop && l0)
            drn_next = D_IDLE;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drn_state <= D_IDLE;
            r <= '0;
            c <= '0;
            dbase <= '0;
            dlen <= '0;
            issued_all <= 1'b0;
            pend <= 1'b0;
            pend_last <= 1'b0;
            pend_col <= '0;
            e0 <= '0;
            e1 <= '0;
            l0 <= 1'b0;
            l1 <= 1'b0;
            cnt <= '0;
        end else begin
            drn_state <= drn_next;
            if (drn_ok) begin
                r <= '0;
                c <= '0;
                dbase <= drain_base;
                dlen <= drain_len;
                issued_all <= 1'b0;
            end else if (issue) begin
                issued_all <= last_issue;
                c <= (c == ncols - 1'b1) ? '0 : c + 1'b1;
                r <= (c == ncols - 1'b1) ? r + 1'b1 : r;
            end
            pend <= issue;
            pend_last <= issue && last_issue;
            pend_col <= c[IW-1:0];
            if (pop) begin
                e0 <= e1;
                l0 <= l1;
            end
            if (pend && lvl == '0) begin
                e0 <= rd_bus[pend_col];
                l0 <= pend_last;
            end else if (pend) begin
                e1 <= rd_bus[pend_col];
                l1 <= pend_last;
            end
            cnt <= cnt + {1'b0, pend} - {1'b0, pop};
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cfg_err <= 1'b0;
        else if ((start && !start_ok) || (drain_start && !drn_ok)) cfg_err <= 1'b1;
        else if (start_ok) cfg_err <= 1'b0;
    end
endmodule

// File: tb/tb_o_buffer_acc.sv
// tb_o_buffer_acc: directed checks of capture, accumulate, drain and rejection behaviour.
module tb_o_buffer_acc;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [3:0] cfg_num_cols = '0;
    logic [8:0] cfg_num_rows = '0;
    logic [7:0] cfg_base_addr = '0;
    logic cfg_acc_mode = 1'b0;
    logic start = 1'b0;
    logic in_valid = 1'b0;
    logic [255:0] in_data = '0;
    logic busy, done, out_valid, out_last, cfg_err;
    logic drain_start = 1'b0;
    logic [7:0] drain_base = '0;
    logic [8:0] drain_len = '0;
    logic out_ready = 1'b0;
    logic [31:0] out_data;
    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q [$];

    o_buffer_acc dut (
        .clk(clk), .reset(reset),
        .cfg_num_cols(cfg_num_cols), .cfg_num_rows(cfg_num_rows),
        .cfg_base_addr(cfg_base_addr), .cfg_acc_mode(cfg_acc_mode),
        .start(start), .in_valid(in_valid), .in_data(in_data),
        .busy(busy), .done(done),
        .drain_start(drain_start), .drain_base(drain_base), .drain_len(drain_len),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic capture(input int cols, input int rows, input int base, input bit acc,
                           input bit gap, input bit konst, input logic [31:0] val,
                           input bit with_drain, input bit poke);
        int nb;
        cfg_num_cols = 4'(cols);
        cfg_num_rows = 9'(rows);
        cfg_base_addr = 8'(base);
        cfg_acc_mode = acc;
        start = 1'b1;
        drain_start = with_drain;
        step();
        start = 1'b0;
        drain_start = 1'b0;
        check("busy_after_start", busy, 1);
        nb = (cols == 0 || rows == 0) ? 0 : rows + ((cols > 8) ? 8 : cols) - 1;
        for (int b = 0; b < nb; b++) begin
            if (gap && b > 0) begin
                in_valid = 1'b0;
                step();
            end
            for (int m = 0; m < 8; m++) in_data[32*m +: 32] = konst ? val : 32'(100*b + m);
            in_valid = 1'b1;
            start = poke && b == 1;
            step();
            start = 1'b0;
        end
        in_valid = 1'b0;
        check("done_early", done, 0);
        step();
        check("done_pulse", done, 1);
        step();
        check("done_clear", done, 0);
        check("busy_clear", busy, 0);
    endtask

    task automatic drain(input int base, input int len, input bit rnd);
        int n;
        int cyc;
        bit held;
        logic [31:0] hd;
        n = 0;
        cyc = 0;
        held = 1'b0;
        hd = '0;
        drain_base = 8'(base);
        drain_len = 9'(len);
        drain_start = 1'b1;
        step();
        drain_start = 1'b0;
        while (n < exp_q.size() && cyc < 3000) begin
            if (held) begin
                check("stall_valid", out_valid, 1);
                check("stall_data", out_data, hd);
            end
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            held = 1'b0;
            if (out_valid && out_ready) begin
                check("drain_data", out_data, exp_q[n]);
                check("drain_last", out_last, n == exp_q.size() - 1);
                n++;
            end else if (out_valid) begin
                held = 1'b1;
                hd = out_data;
            end
            step();
            cyc++;
        end
        out_ready = 1'b0;
        check("drain_count", n, exp_q.size());
        check("drain_idle", out_valid, 0);
    endtask

    initial begin
        int dn;
        logic [31:0] sat_exp;
        repeat (3) step();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_cfg_err", cfg_err, 0);
        check("rst_out_data", out_data, 0);
        reset = 1'b0;
        step();

        capture(4, 3, 10, 0, 0, 0, 0, 0, 0);
        check("ovw_cfg_err", cfg_err, 0);
        exp_q.delete();
        for (int r = 0; r < 3; r++) for (int c = 0; c < 4; c++) exp_q.push_back(32'(100*(r+c) + c));
        drain(10, 3, 0);

        capture(4, 3, 40, 0, 1, 0, 0, 0, 0);
        drain(40, 3, 1);

        capture(4, 4, 20, 0, 0, 1, 32'd1, 0, 0);
        capture(4, 4, 20, 1, 0, 1, 32'd1, 0, 0);
        exp_q.delete();
        for (int i = 0; i < 16; i++) exp_q.push_back(32'd2);
        drain(20, 4, 1);

        capture(1, 1, 30, 0, 0, 1, 32'h7fffffff, 0, 0);
        capture(1, 1, 30, 1, 0, 1, 32'd5, 0, 0);
`ifdef O_BUF_SAT_EN
        sat_exp = 32'h7fffffff;
`else
        sat_exp = 32'h80000004;
`endif
        exp_q.delete();
        exp_q.push_back(sat_exp);
        drain(30, 1, 0);

        capture(15, 4, 254, 0, 0, 0, 0, 0, 0);
        exp_q.delete();
        for (int r = 0; r < 4; r++) for (int c = 0; c < 8; c++) exp_q.push_back(32'(100*(r+c) + c));
        drain(254, 4, 0);
        exp_q.delete();
        for (int r = 2; r < 4; r++) for (int c = 0; c < 8; c++) exp_q.push_back(32'(100*(r+c) + c));
        drain(0, 2, 1);

        exp_q.delete();
        drain(10, 0, 0);
        check("len0_cfg_err", cfg_err, 0);
        capture(0, 3, 100, 0, 0, 0, 0, 0, 0);
        drain(10, 2, 0);

        capture(4, 3, 60, 0, 0, 0, 0, 1, 0);
        check("same_cycle_err", cfg_err, 1);

        capture(4, 3, 70, 0, 0, 0, 0, 0, 1);
        check("start_busy_err", cfg_err, 1);
        exp_q.delete();
        for (int r = 0; r < 3; r++) for (int c = 0; c < 4; c++) exp_q.push_back(32'(100*(r+c) + c));
        drain(70, 3, 0);

        cfg_num_cols = 4'd4;
        cfg_num_rows = 9'd3;
        cfg_base_addr = 8'd80;
        cfg_acc_mode = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        check("err_cleared", cfg_err, 0);
        for (int m = 0; m < 8; m++) in_data[32*m +: 32] = 32'(m);
        in_valid = 1'b1;
        drain_base = 8'd80;
        drain_len = 9'd3;
        drain_start = 1'b1;
        step();
        drain_start = 1'b0;
        check("drain_busy_err", cfg_err, 1);
        check("drain_busy_capt", busy, 1);
        step();
        check("drain_busy_noout", out_valid, 0);
        reset = 1'b1;
        #1;
        check("mid_reset_busy", busy, 0);
        check("mid_reset_err", cfg_err, 0);
        in_valid = 1'b0;
        step();
        reset = 1'b0;
        dn = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (done) dn++;
        end
        check("mid_reset_no_done", dn, 0);
        check("mid_reset_idle", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
